red_sequencer: RTL and testbench
================================

# red_sequencer

Multi-cycle control unit that sequences the register-file/ALU datapath. It fetches 32-bit RV32I instructions from an instruction memory over a req/valid handshake and decodes ADD, SUB, ADDI, BEQ and BNE. For each instruction it drives the datapath's register addresses, write enable, operand select, ALU control and immediate. It owns the PC and resolves branches from the datapath's `eq` output.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value after reset.
- `ADDRESS_WIDTH`, 5: register address width.
- `DATA_WIDTH`, 32: datapath/immediate width.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `imem_req  out  1`: fetch request.
- `imem_addr  out  32`: fetch address, equal to `pc`.
- `imem_valid  in  1`: instruction valid.
- `imem_rdata  in  32`: instruction word.
- `ad1`, `ad2`, `ad3  out  ADDRESS_WIDTH`: rs1, rs2 and rd to the datapath.
- `we3  out  1`: register write enable.
- `aluSrc  out  1`: selects the ALU's second operand. 0 = register (rd2), 1 = `immOp`.
- `aluCTR  out  3`: ALU operation. 3'b000 = add, 3'b001 = sub.
- `immOp  out  DATA_WIDTH`: sign-extended immediate.
- `eq  in  1`: datapath flag. High when ALU operand 1 equals ALU operand 2.
- `pc  out  32`: current PC.
- `halted  out  1`: sequencer stopped.
- `instret  out  32`: retired instruction count. See Configuration.

## Operation
- States: FETCH, EXEC, HALT. Reset enters FETCH with `pc`=`RESET_PC` and IR=0.
- **FETCH**
  - `imem_req`=1 and `imem_addr`=`pc`.
  - A rising edge with `imem_valid`=1 latches `imem_rdata` into IR and moves to EXEC.
  - Otherwise the state stays in FETCH, with the request and address held stable.
- **EXEC**: one cycle. Datapath controls are decoded combinationally from IR. At the closing edge the state returns to FETCH, or moves to HALT.
  - ADD (opcode 0110011, funct3 000, funct7 0000000): `ad1`=rs1, `ad2`=rs2, `ad3`=rd, `aluSrc`=0, `aluCTR`=000, `we3`=1. `pc`+=4.
  - SUB (same opcode and funct3, funct7 0100000): as ADD, except `aluCTR`=001.
  - ADDI (opcode 0010011, funct3 000):
    - `ad1`=rs1, `ad3`=rd, `aluSrc`=1, `aluCTR`=000, `we3`=1.
    - `immOp`=sign-extended IR[31:20].
    - `pc`+=4.
  - BEQ/BNE (opcode 1100011, funct3 000/001):
    - `ad1`=rs1, `ad2`=rs2, `aluSrc`=0, `aluCTR`=001, `we3`=0.
    - `immOp`=sign-extended B-immediate.
    - `eq` is sampled at the EXEC edge. The branch is taken for BEQ when `eq`=1 and for BNE when `eq`=0.
    - Taken: `pc`=`pc`+imm. Not taken: `pc`+=4.
  - Whenever rd=0, `we3` is forced to 0.
- **Error cases**: any other encoding, or a taken branch whose target has [1:0]≠0, moves to HALT. The instruction is not retired and `pc` is unchanged.
- **HALT**: terminal until reset. `halted`=1, `imem_req`=0, `we3`=0.
- **Outputs outside EXEC**: `ad1`/`ad2`/`ad3`/`aluCTR`/`immOp`=0, `aluSrc`=0, `we3`=0.
- **Arithmetic**: PC arithmetic is modulo 2^32. `immOp` is sign-extended to `DATA_WIDTH`.

## Timing
- **Reset values**: `pc`=`RESET_PC`, `imem_req`=1 (FETCH), `halted`=0, `instret`=0, all datapath controls 0.
- **Latency**: minimum 2 cycles per instruction (1 FETCH + 1 EXEC). Each FETCH wait cycle adds one cycle.
- **Handshake**:
  - `imem_valid` may be asserted in the same cycle as `imem_req` (zero-wait memory).
  - `imem_valid` is ignored outside FETCH.
  - `imem_rdata` is sampled only on the accepting edge.
- **Register write**: occurs at the EXEC closing edge, through the datapath. A following instruction reading the same register sees the new value.
- **Reset mid-operation**: reset asserted in any state immediately forces FETCH outputs and reset values. An in-flight fetch is abandoned and an EXEC write is suppressed (`we3` drops asynchronously).

## Configuration
- **`RED_SEQ_INSTRET_EN` defined**:
  - `instret` is a 32-bit counter, reset to 0, incremented at every EXEC edge that retires an instruction. Halting instructions are not counted.
  - The counter wraps from 32'hFFFF_FFFF to 0.
- **`RED_SEQ_INSTRET_EN` undefined**: `instret` is tied to 0 and no counter flops are instantiated.

## Test plan
- **Reset and first fetch**: `rst` pulse, zero-wait memory returning ADDI x1,x0,5 (32'h00500093) -> `imem_addr`=0. The next cycle is EXEC with `ad3`=1, `aluSrc`=1, `immOp`=5, `we3`=1. Then `pc`=4 and `instret`=1.
- **Wait states**: `imem_valid` held low for 3 cycles -> `imem_req`=1 and `imem_addr` stable throughout. EXEC occurs exactly 1 cycle after valid.
- **Branches**:
  - BNE x1,x0,-4 at `pc`=8 with `eq`=0 -> `pc`=4.
  - The same instruction with `eq`=1 -> `pc`=12.
  - BEQ with `eq`=1, offset +8 -> `pc`+8.
- **rd=x0 and SUB**:
  - ADD x0,x1,x2 -> `we3`=0 in EXEC.
  - SUB x3,x1,x2 -> `aluCTR`=001, `aluSrc`=0, `we3`=1.
- **Illegal encodings**:
  - Instruction 32'h0000_0000 -> HALT: `halted`=1, `imem_req`=0, `pc` unchanged, `instret` unchanged. Reset recovers to `pc`=`RESET_PC`.
  - A taken branch with offset +2 -> HALT.
- **Reset mid-EXEC**: `rst` asserted during the EXEC of ADDI -> `we3` drops in the same cycle, `pc`=`RESET_PC`, state FETCH.

Source files
------------

// File: rtl/red_sequencer.sv
// red_sequencer: multi-cycle FETCH/EXEC control unit for an RV32I subset (ADD, SUB, ADDI, BEQ, BNE).
// Define RED_SEQ_INSTRET_EN to build the retired-instruction counter driven on instret.
module red_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_valid,
    input  logic [31:0]              imem_rdata,
    output logic [ADDRESS_WIDTH-1:0] ad1,
    output logic [ADDRESS_WIDTH-1:0] ad2,
    output logic [ADDRESS_WIDTH-1:0] ad3,
    output logic                     we3,
    output logic                     aluSrc,
    output logic [2:0]               aluCTR,
    output logic [DATA_WIDTH-1:0]    immOp,
    input  logic                     eq,
    output logic [31:0]              pc,
    output logic                     halted,
    output logic [31:0]              instret
);

    typedef enum logic [1:0] {
        StFetch,
        StExec,
        StHalt
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] ir_q;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_b;
    logic        is_add;
    logic        is_sub;
    logic        is_addi;
    logic        is_beq;
    logic        is_bne;
    logic        legal;
    logic        taken;
    logic [31:0] br_target;
    logic        misaligned;
    logic        retire;
    logic [31:0] pc_next;

    always_comb begin
        opcode     = ir_q[6:0];
        rd         = ir_q[11:7];
        funct3     = ir_q[14:12];
        rs1        = ir_q[19:15];
        rs2        = ir_q[24:20];
        funct7     = ir_q[31:25];
        imm_i      = {{20{ir_q[31]}}, ir_q[31:20]};
        imm_b      = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
        is_add     = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
        is_sub     = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
        is_addi    = (opcode == 7'b0010011) && (funct3 == 3'b000);
        is_beq     = (opcode == 7'b1100011) && (funct3 == 3'b000);
        is_bne     = (opcode == 7'b1100011) && (funct3 == 3'b001);
        legal      = is_add || is_sub || is_addi || is_beq || is_bne;
        taken      = (is_beq && eq) || (is_bne && !eq);
        br_target  = pc_q + imm_b;
        // Only a taken branch can produce a misaligned PC; a not-taken one falls through.
        misaligned = taken && (br_target[1:0] != 2'b00);
        retire     = (state_q == StExec) && legal && !misaligned;
        pc_next    = taken ? br_target : pc_q + 32'd4;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            case (state_q)
                StFetch: begin
                    if (imem_valid) begin
                        ir_q    <= imem_rdata;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    if (retire) begin
                        pc_q    <= pc_next;
                        state_q <= StFetch;
                    end else begin
                        state_q <= StHalt;
                    end
                end
                StHalt:  state_q <= StHalt;
                default: state_q <= StHalt;
            endcase
        end
    end

`ifdef RED_SEQ_INSTRET_EN
    logic [31:0] instret_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

    assign imem_req  = (state_q == StFetch);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign halted    = (state_q == StHalt);

    // Controls follow the registered state, so reset clears them without waiting for an edge.
    always_comb begin
        ad1    = '0;
        ad2    = '0;
        ad3    = '0;
        we3    = 1'b0;
        aluSrc = 1'b0;
        aluCTR = 3'b000;
        immOp  = '0;
        if (state_q == StExec) begin
            if (is_add || is_sub) begin
                ad1    = ADDRESS_WIDTH'(rs1);
                ad2    = ADDRESS_WIDTH'(rs2);
                ad3    = ADDRESS_WIDTH'(rd);
                we3    = (rd != 5'd0);
                aluCTR = is_sub ? 3'b001 : 3'b000;
            end else if (is_addi) begin
                ad1    = ADDRESS_WIDTH'(rs1);
                ad3    = ADDRESS_WIDTH'(rd);
                we3    = (rd != 5'd0);
                aluSrc = 1'b1;
                immOp  = DATA_WIDTH'($signed(imm_i));
            end else if (is_beq || is_bne) begin
                ad1    = ADDRESS_WIDTH'(rs1);
                ad2    = ADDRESS_WIDTH'(rs2);
                aluCTR = 3'b001;
                immOp  = DATA_WIDTH'($signed(imm_b));
            end
        end
    end

endmodule

// File: tb/tb_red_sequencer.sv
// Scoreboard bench for red_sequencer: expected EXEC controls and next PC are queued per instruction.
module tb_red_sequencer;

`ifdef RED_SEQ_INSTRET_EN
    localparam bit InstretEn = 1'b1;
`else
    localparam bit InstretEn = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [4:0]  ad1;
    logic [4:0]  ad2;
    logic [4:0]  ad3;
    logic        we3;
    logic        aluSrc;
    logic [2:0]  aluCTR;
    logic [31:0] immOp;
    logic        eq;
    logic [31:0] pc;
    logic        halted;
    logic [31:0] instret;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] fetch_pc;
        logic [4:0]  ad1;
        logic [4:0]  ad2;
        logic [4:0]  ad3;
        logic        we3;
        logic        src;
        logic [2:0]  ctr;
        logic [31:0] imm;
        logic [31:0] pc_after;
        logic        halt;
        bit          chk_ctl;
        bit          chk_ad2;
        bit          chk_ad3;
        bit          chk_imm;
    } exp_t;

    exp_t sb[$];

    red_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .ad1        (ad1),
        .ad2        (ad2),
        .ad3        (ad3),
        .we3        (we3),
        .aluSrc     (aluSrc),
        .aluCTR     (aluCTR),
        .immOp      (immOp),
        .eq         (eq),
        .pc         (pc),
        .halted     (halted),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [4:0] rd);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [4:0] rd);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] exp_instret(input int n);
        return InstretEn ? 32'(n) : 32'd0;
    endfunction

    task automatic push_exp(input logic [31:0] fetch_pc, input logic [4:0] e_ad1,
                            input logic [4:0] e_ad2, input logic [4:0] e_ad3, input logic e_we3,
                            input logic e_src, input logic [2:0] e_ctr, input logic [31:0] e_imm,
                            input logic [31:0] pc_after, input logic halt, input logic [3:0] mask);
        exp_t e;
        e.fetch_pc = fetch_pc;
        e.ad1      = e_ad1;
        e.ad2      = e_ad2;
        e.ad3      = e_ad3;
        e.we3      = e_we3;
        e.src      = e_src;
        e.ctr      = e_ctr;
        e.imm      = e_imm;
        e.pc_after = pc_after;
        e.halt     = halt;
        e.chk_ctl  = mask[3];
        e.chk_ad2  = mask[2];
        e.chk_ad3  = mask[1];
        e.chk_imm  = mask[0];
        sb.push_back(e);
    endtask

    // Entered and left on a falling edge with the DUT in FETCH.
    task automatic run_instr(input string name, input logic [31:0] instr, input int waits,
                             input logic eq_val);
        exp_t e;
        tests_run++;
        if (sb.size() == 0) begin
            tests_failed++;
            $display("FAIL %s scoreboard: queue empty, required one entry", name);
            return;
        end
        e = sb.pop_front();
        for (int w = 0; w <= waits; w++) begin
            imem_valid = 1'b0;
            imem_rdata = $urandom();
            tests_run++;
            if (imem_req !== 1'b1 || imem_addr !== e.fetch_pc) begin
                tests_failed++;
                $display("FAIL %s fetch%0d: req=%b addr=%h, required req=1 addr=%h",
                         name, w, imem_req, imem_addr, e.fetch_pc);
            end
            if (w < waits) @(negedge clk);
        end
        imem_valid = 1'b1;
        imem_rdata = instr;
        @(negedge clk);
        // In EXEC: a valid strobe with junk data must be ignored.
        imem_valid = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        eq = eq_val;
        #1;
        tests_run++;
        if (imem_req !== 1'b0 || halted !== 1'b0 || we3 !== e.we3) begin
            tests_failed++;
            $display("FAIL %s exec: req=%b halted=%b we3=%b, required req=0 halted=0 we3=%b",
                     name, imem_req, halted, we3, e.we3);
        end
        if (e.chk_ctl) begin
            tests_run++;
            if (ad1 !== e.ad1 || aluSrc !== e.src || aluCTR !== e.ctr) begin
                tests_failed++;
                $display("FAIL %s ctl: ad1=%0d aluSrc=%b aluCTR=%b, required %0d %b %b",
                         name, ad1, aluSrc, aluCTR, e.ad1, e.src, e.ctr);
            end
        end
        if (e.chk_ad2) begin
            tests_run++;
            if (ad2 !== e.ad2) begin
                tests_failed++;
                $display("FAIL %s ad2: got %0d, required %0d", name, ad2, e.ad2);
            end
        end
        if (e.chk_ad3) begin
            tests_run++;
            if (ad3 !== e.ad3) begin
                tests_failed++;
                $display("FAIL %s ad3: got %0d, required %0d", name, ad3, e.ad3);
            end
        end
        if (e.chk_imm) begin
            tests_run++;
            if (immOp !== e.imm) begin
                tests_failed++;
                $display("FAIL %s immOp: got %h, required %h", name, immOp, e.imm);
            end
        end
        @(negedge clk);
        imem_valid = 1'b0;
        eq = 1'b0;
        tests_run++;
        if (pc !== e.pc_after || halted !== e.halt || imem_req !== !e.halt) begin
            tests_failed++;
            $display("FAIL %s after: pc=%h halted=%b req=%b, required pc=%h halted=%b req=%b",
                     name, pc, halted, imem_req, e.pc_after, e.halt, !e.halt);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        imem_valid = 1'b0;
        eq = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_instret(input string name, input int n);
        tests_run++;
        if (instret !== exp_instret(n)) begin
            tests_failed++;
            $display("FAIL %s instret: got %0d, required %0d", name, instret, exp_instret(n));
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        imem_valid = 1'b0;
        eq = 1'b0;
        #1;
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || pc !== 32'h0 || halted !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset state: req=%b addr=%h pc=%h halted=%b, required 1 0 0 0",
                     imem_req, imem_addr, pc, halted);
        end
        tests_run++;
        if ({ad1, ad2, ad3, we3, aluSrc, aluCTR} !== 20'h0 || immOp !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset controls: ad=%0d/%0d/%0d we3=%b src=%b ctr=%b imm=%h, required 0",
                     ad1, ad2, ad3, we3, aluSrc, aluCTR, immOp);
        end
        check_instret("reset", 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_first_fetch();
        push_exp(32'd0, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 3'b000, 32'd5, 32'd4, 1'b0, 4'b1011);
        run_instr("addi_x1_5", 32'h0050_0093, 0, 1'b0);
        check_instret("first_fetch", 1);
    endtask

    task automatic test_wait_states();
        push_exp(32'd4, 5'd0, 5'd0, 5'd2, 1'b1, 1'b1, 3'b000, 32'hFFFF_FFFD, 32'd8, 1'b0,
                 4'b1011);
        run_instr("addi_wait3", enc_i(12'hFFD, 5'd0, 5'd2), 3, 1'b0);
    endtask

    task automatic test_branches();
        push_exp(32'd8, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 3'b001, 32'hFFFF_FFFC, 32'd4, 1'b0,
                 4'b1101);
        run_instr("bne_taken", enc_b(13'h1FFC, 5'd0, 5'd1, 3'b001), 0, 1'b0);
        push_exp(32'd4, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 3'b000, 32'd0, 32'd8, 1'b0, 4'b1011);
        run_instr("nop_rd0", enc_i(12'h000, 5'd0, 5'd0), 0, 1'b0);
        push_exp(32'd8, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 3'b001, 32'hFFFF_FFFC, 32'd12, 1'b0,
                 4'b1101);
        run_instr("bne_not_taken", enc_b(13'h1FFC, 5'd0, 5'd1, 3'b001), 0, 1'b1);
        push_exp(32'd12, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 3'b001, 32'd8, 32'd20, 1'b0, 4'b1101);
        run_instr("beq_taken", enc_b(13'd8, 5'd2, 5'd1, 3'b000), 0, 1'b1);
        push_exp(32'd20, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 3'b001, 32'd8, 32'd24, 1'b0, 4'b1101);
        run_instr("beq_not_taken", enc_b(13'd8, 5'd2, 5'd1, 3'b000), 0, 1'b0);
    endtask

    task automatic test_rd0_sub();
        push_exp(32'd24, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd28, 1'b0, 4'b1110);
        run_instr("add_x0", enc_r(7'b0000000, 5'd2, 5'd1, 5'd0), 0, 1'b0);
        push_exp(32'd28, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 3'b001, 32'd0, 32'd32, 1'b0, 4'b1110);
        run_instr("sub_x3", enc_r(7'b0100000, 5'd2, 5'd1, 5'd3), 0, 1'b0);
        check_instret("after_sub", 9);
    endtask

    task automatic test_illegal();
        push_exp(32'd32, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd32, 1'b1, 4'b0000);
        run_instr("zero_word", 32'h0000_0000, 0, 1'b0);
        check_instret("zero_word", 9);
        for (int i = 0; i < 3; i++) begin
            imem_valid = 1'b1;
            imem_rdata = 32'h0050_0093;
            @(negedge clk);
            tests_run++;
            if (halted !== 1'b1 || imem_req !== 1'b0 || we3 !== 1'b0 || pc !== 32'd32) begin
                tests_failed++;
                $display("FAIL halt_hold%0d: halted=%b req=%b we3=%b pc=%h, required 1 0 0 20",
                         i, halted, imem_req, we3, pc);
            end
        end
        imem_valid = 1'b0;
        do_reset();
        tests_run++;
        if (pc !== 32'd0 || halted !== 1'b0 || imem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL halt_recover: pc=%h halted=%b req=%b, required 0 0 1",
                     pc, halted, imem_req);
        end
        push_exp(32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b1, 4'b0000);
        run_instr("mul_funct7", enc_r(7'b0000001, 5'd3, 5'd2, 5'd1), 0, 1'b0);
        check_instret("mul_funct7", 0);
        do_reset();
    endtask

    task automatic test_misaligned();
        push_exp(32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 3'b001, 32'd2, 32'd4, 1'b0, 4'b1101);
        run_instr("bne_odd_not_taken", enc_b(13'd2, 5'd0, 5'd0, 3'b001), 0, 1'b1);
        push_exp(32'd4, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 3'b001, 32'd2, 32'd4, 1'b1, 4'b1101);
        run_instr("beq_odd_taken", enc_b(13'd2, 5'd0, 5'd0, 3'b000), 0, 1'b1);
        check_instret("misaligned", 1);
        do_reset();
    endtask

    task automatic test_reset_mid_exec();
        imem_valid = 1'b1;
        imem_rdata = enc_i(12'd7, 5'd0, 5'd5);
        @(negedge clk);
        imem_valid = 1'b0;
        #1;
        tests_run++;
        if (we3 !== 1'b1 || ad3 !== 5'd5) begin
            tests_failed++;
            $display("FAIL mid_exec pre: we3=%b ad3=%0d, required 1 5", we3, ad3);
        end
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (we3 !== 1'b0 || pc !== 32'd0 || imem_req !== 1'b1 || ad3 !== 5'd0) begin
            tests_failed++;
            $display("FAIL mid_exec rst: we3=%b pc=%h req=%b ad3=%0d, required 0 0 1 0",
                     we3, pc, imem_req, ad3);
        end
        @(negedge clk);
        rst = 1'b0;
        check_instret("mid_exec", 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            push_exp(32'(4 * i), 5'd0, 5'd0, 5'(5 + i), 1'b1, 1'b1, 3'b000, 32'(i + 1),
                     32'(4 * i + 4), 1'b0, 4'b1011);
            run_instr("b2b_addi", enc_i(12'(i + 1), 5'd0, 5'(5 + i)), 0, 1'b0);
        end
        check_instret("back_to_back", 3);
    endtask

    initial begin
        rst = 1'b1;
        imem_valid = 1'b0;
        imem_rdata = '0;
        eq = 1'b0;
        test_reset();
        test_first_fetch();
        test_wait_states();
        test_branches();
        test_rd0_sub();
        test_illegal();
        test_misaligned();
        test_reset_mid_exec();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
